fp_mul_param: RTL and testbench
===============================

// Module: fp_mul_param
// PURPOSE
//  Parametrised IEEE-754 binary multiplier: any exponent/fraction width, default single precision.
//  Multi-cycle FSM datapath with valid/ready handshakes on input and output.
//  Round-to-nearest-even and IEEE status flags (invalid/overflow/underflow/inexact).
//  Sits between the operand dispatcher and the result writeback, same slot as the FP units.
// PARAMETERS
//  EXP_W  8   exponent field width; BIAS = 2**(EXP_W-1)-1
//  MAN_W  23  stored fraction width; W = 1+EXP_W+MAN_W
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  in_valid   in   1   op_a/op_b valid
//  in_ready   out  1   block can accept operands (state IDLE)
//  op_a       in   W   operand A, IEEE packed
//  op_b       in   W   operand B, IEEE packed
//  out_valid  out  1   res/flags valid
//  out_ready  in   1   consumer accepts result
//  res        out  W   product, IEEE packed
//  flags      out  4   {invalid, overflow, underflow, inexact}
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, res=0, flags=0, all internal regs 0; reset mid-op aborts, no output.
//  States: IDLE,CLASS,MUL,NORM,ROUND,PACK,OUT. in_ready = (state==IDLE) only.
//  IDLE: in_valid=1 -> capture sign/exp/{hidden,frac} of both ops at edge k -> CLASS.
//  CLASS: exp all-ones & frac!=0 -> NaN; all-ones & frac==0 -> Inf; exp==0 -> Zero (subnormal inputs flushed to zero, no flag).
//   Result class: any NaN or Inf*Zero -> NaN (invalid=1); else any Zero -> Zero; else any Inf -> Inf; else NUM.
//   NUM -> MUL; special -> PACK.
//  MUL: e = e_a+e_b-BIAS in EXP_W+2-bit signed; p = m_a*m_b, 2*(MAN_W+1) bits.
//  NORM: p MSB set -> e+=1, keep top MAN_W+1 bits; else shift left 1. Extract G (next bit), S (OR of rest).
//  ROUND: RNE: increment if G & (S | lsb). Mantissa carry-out -> mantissa=1.0, e+=1. inexact = G|S.
//  PACK: NUM: e >= 2**EXP_W-1 -> +/-Inf, overflow=1, inexact=1; e <= 0 -> signed zero, underflow=1, inexact=1 (flush, no subnormal out).
//   Zero/Inf: sign=s_a^s_b, exp 0 / all-ones, frac 0. NaN: canonical quiet NaN, sign 0, exp all-ones, frac MSB 1 rest 0.
//  OUT: out_valid=1; res/flags stable while out_ready=0; out_valid&out_ready -> IDLE, out_valid=0 next cycle.
//  Latency accept->out_valid: NUM path 6 cycles (out_valid high from edge k+6), special path 3 cycles (edge k+3).
//  Throughput: one op in flight; next accept no earlier than cycle after result handshake.
//  in_valid ignored outside IDLE; op_a/op_b may change freely after accept.
//  flags are per-operation (not sticky), cleared on each accept.
// STRUCTURE
//  Package fp_pkg: class enum {FP_NUM,FP_ZERO,FP_INF,FP_NAN}, state enum, flag bit indices,
//   functions fp_bias(EXP_W), fp_qnan(EXP_W,MAN_W).
//  One sub-module fp_classify (combinational, per operand): packed -> {sign, exp, mant, class}; two instances.
//  Multiplier inferred as a single registered multiply in MUL; no vendor primitives.
// TESTING
//  0x3FC00000*0x40000000 (1.5*2.0) -> res 0x40400000, flags 0000, out_valid exactly 6 cycles after accept.
//  0x3F800001*0x3FC00000 (RNE tie, odd lsb) -> 0x3FC00002, inexact=1; 0x3F800001*0x3F800001 -> 0x3F800002, inexact=1.
//  0x7F800000*0x00000000 -> 0x7FC00000, invalid=1, 3-cycle latency; 0xFF800000*0x40000000 -> 0xFF800000, flags 0.
//  0x7F000000*0x7F000000 -> 0x7F800000, overflow=1, inexact=1; 0x00800000*0x00800000 -> 0x00000000, underflow=1, inexact=1.
//  out_ready held low 5 cycles in OUT -> res/flags/out_valid stable, in_ready=0; then handshake -> in_ready=1 next cycle.
//  rst pulsed while in MUL -> out_valid stays 0, in_ready=1, res=0; EXP_W=5,MAN_W=10: 0x3C00*0x4000 -> 0x4000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and helpers for the parametrised IEEE-754 multiplier.
// Operand classes, FSM state encoding, flag bit positions, bias and quiet-NaN constants.
package fp_pkg;

    typedef enum logic [1:0] {
        FP_NUM  = 2'd0,
        FP_ZERO = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp_class_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLASS = 3'd1,
        ST_MUL   = 3'd2,
        ST_NORM  = 3'd3,
        ST_ROUND = 3'd4,
        ST_PACK  = 3'd5,
        ST_OUT   = 3'd6
    } fp_state_e;

    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB only.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand unpacker: sign, exponent, mantissa with hidden bit, and class.
// Subnormal encodings are treated as zero.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] op_i,
    output logic                 sign_o,
    output logic [EXP_W-1:0]     exp_o,
    output logic [MAN_W:0]       mant_o,
    output fp_class_e            cls_o
);

    logic [EXP_W-1:0] exp_s;
    logic [MAN_W-1:0] frac_s;

    assign exp_s  = op_i[MAN_W +: EXP_W];
    assign frac_s = op_i[MAN_W-1:0];
    assign sign_o = op_i[EXP_W+MAN_W];
    assign exp_o  = exp_s;
    assign mant_o = {(|exp_s), frac_s};

    // Class decode from the exponent/fraction fields
    always_comb begin
        cls_o = FP_NUM;
        if (&exp_s) begin
            if (|frac_s) begin
                cls_o = FP_NAN;
            end else begin
                cls_o = FP_INF;
            end
        end else if (exp_s == {EXP_W{1'b0}}) begin
            cls_o = FP_ZERO;
        end else begin
            cls_o = FP_NUM;
        end
    end

endmodule

// File: rtl/fp_mul_param.sv
// Multi-cycle IEEE-754 multiplier, any exponent/fraction width, round-to-nearest-even.
// One operation in flight; valid/ready on both sides; per-operation status flags.
module fp_mul_param
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_W+MAN_W:0]       op_a,
    input  logic [EXP_W+MAN_W:0]       op_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EXP_W+MAN_W:0]       res,
    output logic [3:0]                 flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;
    localparam int P  = 2 * M;
    localparam int EW = EXP_W + 2;

    localparam logic signed [EW-1:0] BIAS_E = EW'(fp_bias(EXP_W));
    localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_E = EW'(0);
    localparam logic [W-1:0]         QNAN   = W'(fp_qnan(EXP_W, MAN_W));

    fp_state_e              state_q;
    logic [W-1:0]           a_q, b_q;
    fp_class_e              rcls_q;
    logic                   s_q;
    logic signed [EW-1:0]   e_q;
    logic [P-1:0]           p_q;
    logic [M-1:0]           mant_q;
    logic                   g_q, sticky_q;
    logic [W-1:0]           res_q;
    logic [3:0]             flags_q;
    logic                   out_valid_q, in_ready_q;

    logic                   sign_a_s, sign_b_s;
    logic [EXP_W-1:0]       exp_a_s, exp_b_s;
    logic [M-1:0]           mant_a_s, mant_b_s;
    fp_class_e              cls_a_s, cls_b_s, rcls_s;
    logic [P-1:0]           pn_s;
    logic                   inc_s;
    logic [M:0]             sum_s;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .op_i(a_q), .sign_o(sign_a_s), .exp_o(exp_a_s), .mant_o(mant_a_s), .cls_o(cls_a_s)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .op_i(b_q), .sign_o(sign_b_s), .exp_o(exp_b_s), .mant_o(mant_b_s), .cls_o(cls_b_s)
    );

    // Result class: NaN dominates (including Inf*0), then zero, then infinity
    always_comb begin
        rcls_s = FP_NUM;
        if ((cls_a_s == FP_NAN) || (cls_b_s == FP_NAN) ||
            ((cls_a_s == FP_INF) && (cls_b_s == FP_ZERO)) ||
            ((cls_a_s == FP_ZERO) && (cls_b_s == FP_INF))) begin
            rcls_s = FP_NAN;
        end else if ((cls_a_s == FP_ZERO) || (cls_b_s == FP_ZERO)) begin
            rcls_s = FP_ZERO;
        end else if ((cls_a_s == FP_INF) || (cls_b_s == FP_INF)) begin
            rcls_s = FP_INF;
        end else begin
            rcls_s = FP_NUM;
        end
    end

    // Normalised product (leading one at MSB) and round-to-nearest-even increment
    always_comb begin
        pn_s = p_q;
        if (p_q[P-1]) begin
            pn_s = p_q;
        end else begin
            pn_s = p_q << 1;
        end
        inc_s = g_q & (sticky_q | mant_q[0]);
        sum_s = {1'b0, mant_q} + (M+1)'(inc_s);
    end

    // Control FSM and datapath registers, including all outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            rcls_q      <= FP_NUM;
            s_q         <= 1'b0;
            e_q         <= '0;
            p_q         <= '0;
            mant_q      <= '0;
            g_q         <= 1'b0;
            sticky_q    <= 1'b0;
            res_q       <= '0;
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= op_a;
                        b_q        <= op_b;
                        flags_q    <= 4'b0000;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_CLASS;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_CLASS: begin
                    rcls_q               <= rcls_s;
                    s_q                  <= sign_a_s ^ sign_b_s;
                    flags_q[FLG_INVALID] <= (rcls_s == FP_NAN);
                    state_q              <= (rcls_s == FP_NUM) ? ST_MUL : ST_PACK;
                end
                ST_MUL: begin
                    e_q     <= $signed({2'b00, exp_a_s}) + $signed({2'b00, exp_b_s}) - BIAS_E;
                    p_q     <= P'(mant_a_s) * P'(mant_b_s);
                    state_q <= ST_NORM;
                end
                ST_NORM: begin
                    if (p_q[P-1]) begin
                        e_q <= e_q + ONE_E;
                    end else begin
                        e_q <= e_q;
                    end
                    mant_q   <= pn_s[P-1 -: M];
                    g_q      <= pn_s[M-1];
                    sticky_q <= |pn_s[M-2:0];
                    state_q  <= ST_ROUND;
                end
                ST_ROUND: begin
                    // Rounding 1.11..1 up wraps the mantissa to 1.0 and bumps the exponent
                    if (sum_s[M]) begin
                        mant_q <= {1'b1, {MAN_W{1'b0}}};
                        e_q    <= e_q + ONE_E;
                    end else begin
                        mant_q <= sum_s[M-1:0];
                    end
                    flags_q[FLG_INEXACT] <= g_q | sticky_q;
                    state_q              <= ST_PACK;
                end
                ST_PACK: begin
                    case (rcls_q)
                        FP_NAN:  res_q <= QNAN;
                        FP_ZERO: res_q <= {s_q, {(W-1){1'b0}}};
                        FP_INF:  res_q <= {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        FP_NUM: begin
                            if (e_q >= EMAX_E) begin
                                res_q                  <= {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                                flags_q[FLG_OVERFLOW]  <= 1'b1;
                                flags_q[FLG_INEXACT]   <= 1'b1;
                            end else if (e_q <= ZERO_E) begin
                                res_q                  <= {s_q, {(W-1){1'b0}}};
                                flags_q[FLG_UNDERFLOW] <= 1'b1;
                                flags_q[FLG_INEXACT]   <= 1'b1;
                            end else begin
                                res_q <= {s_q, e_q[EXP_W-1:0], mant_q[MAN_W-1:0]};
                            end
                        end
                        default: res_q <= QNAN;
                    endcase
                    state_q <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_param.sv
// Scoreboard bench for fp_mul_param: directed corner cases plus randomized single-precision
// operands against an integer-arithmetic reference model, and one half-precision instance.
module tb_fp_mul_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] op_a, op_b, res;
    logic [3:0]  flags;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_op_a, h_op_b, h_res;
    logic [3:0]  h_flags;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hold_left = 0;
    bit rnd_ready = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    bit   cur_active = 1'b0;
    bit   hs_pending = 1'b0;

    fp_mul_param #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .flags(flags)
    );

    fp_mul_param #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .op_a(h_op_a), .op_b(h_op_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .res(h_res), .flags(h_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: value-level IEEE multiply with RNE, FTZ inputs and flush-to-zero outputs
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
        int ea, eb, e, sh;
        longint unsigned fa, fb, p, q, rem, half;
        bit an, bn, ai, bi, az, bz, sg, inexact;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = longint'(a[22:0]); fb = longint'(b[22:0]);
        an = (ea == 255) && (fa != 0); bn = (eb == 255) && (fb != 0);
        ai = (ea == 255) && (fa == 0); bi = (eb == 255) && (fb == 0);
        az = (ea == 0);                bz = (eb == 0);
        sg = a[31] ^ b[31];
        lat = 3;
        f = 4'b0000;
        if (an || bn || (ai && bz) || (bi && az)) begin
            r = 32'h7FC00000; f = 4'b1000;
        end else if (az || bz) begin
            r = {sg, 31'd0};
        end else if (ai || bi) begin
            r = {sg, 8'hFF, 23'd0};
        end else begin
            lat = 6;
            p = ((64'd1 << 23) + fa) * ((64'd1 << 23) + fb);
            e = ea + eb - 127;
            if (p >= (64'd1 << 47)) begin sh = 24; e++; end
            else sh = 23;
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            inexact = (rem != 0);
            if ((rem > half) || ((rem == half) && q[0])) q++;
            if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
            if (e >= 255) begin
                r = {sg, 8'hFF, 23'd0}; f = 4'b0101 | 4'b0010 & 4'b0000; f = 4'b0101;
            end else if (e <= 0) begin
                r = {sg, 31'd0}; f = 4'b0011;
            end else begin
                r = {sg, 8'(e), q[22:0]}; f = {3'b000, inexact};
            end
        end
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        int sel;
        v   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel == 0) v[30:23] = 8'h00;
        else if (sel == 1) begin
            v[30:23] = 8'hFF;
            if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0;
        end else if (sel == 2) v[15:0] = 16'd0;
        else if (sel > 4) v[30:23] = 8'($urandom_range(70, 185));
        return v;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit push);
        int n;
        logic [31:0] r;
        logic [3:0]  f;
        int lat;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; op_a = a; op_b = b;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            model(a, b, r, f, lat);
            sbq.push_back('{res: r, flags: f, lat: lat, acc: cyc + 1});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || cur_active || hs_pending) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0 || cur_active) fail_now("drain_timeout");
    endtask

    // Consumer ready: optional forced hold while a result is presented, else random or always-ready
    always @(posedge clk) begin
        #1;
        if (hold_left > 0) begin
            out_ready = 1'b0;
            if (out_valid) hold_left--;
        end else if (rnd_ready) begin
            out_ready = 1'($urandom_range(0, 1));
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each new result and checks hold stability and handshake
    always @(negedge clk) begin
        if (rst) begin
            cur_active = 1'b0;
            hs_pending = 1'b0;
        end else begin
            if (hs_pending) begin
                chk("post_hs_in_ready", 32'(in_ready), 32'd1);
                chk("post_hs_out_valid", 32'(out_valid), 32'd0);
                hs_pending = 1'b0;
            end
            if (out_valid) begin
                if (!cur_active) begin
                    if (sbq.size() == 0) begin
                        fail_now("unexpected_out");
                    end else begin
                        cur = sbq.pop_front();
                        cur_active = 1'b1;
                        chk("res", res, cur.res);
                        chk("flags", 32'(flags), 32'(cur.flags));
                        chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    end
                end else begin
                    chk("hold_res", res, cur.res);
                    chk("hold_flags", 32'(flags), 32'(cur.flags));
                    chk("busy_in_ready", 32'(in_ready), 32'd0);
                end
                if (cur_active && out_ready) begin
                    hs_pending = 1'b1;
                    cur_active = 1'b0;
                end
            end else if (cur_active) begin
                fail_now("valid_dropped");
                cur_active = 1'b0;
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0; op_a = 32'd0; op_b = 32'd0;
        h_in_valid = 1'b0; h_op_a = 16'd0; h_op_b = 16'd0; h_out_ready = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(32'h3FC00000, 32'h40000000, 1'b1);
        send(32'h3F800001, 32'h3FC00000, 1'b1);
        send(32'h3F800001, 32'h3F800001, 1'b1);
        send(32'h7F800000, 32'h00000000, 1'b1);
        send(32'hFF800000, 32'h40000000, 1'b1);
        send(32'h7F000000, 32'h7F000000, 1'b1);
        send(32'h00800000, 32'h00800000, 1'b1);
        send(32'h7FC12345, 32'h3F800000, 1'b1);
        send(32'h80000000, 32'h3F800000, 1'b1);
        send(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1);
        drain();

        hold_left = 5;
        send(32'h3FC00000, 32'h40000000, 1'b1);
        drain();

        rnd_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(rnd_op(), rnd_op(), 1'b1);
        end
        drain();
        rnd_ready = 1'b0;

        send(32'h3FC00000, 32'h40000000, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_res", res, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midrst_no_out", 32'(out_valid), 32'd0);
        end

        @(negedge clk);
        h_in_valid = 1'b1; h_op_a = 16'h3C00; h_op_b = 16'h4000;
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
        n = 0;
        while (!h_out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (h_out_valid) begin
            chk("half_res", 32'(h_res), 32'h00004000);
            chk("half_flags", 32'(h_flags), 32'd0);
        end else begin
            fail_now("half_timeout");
        end

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
